// File: rtl/chunked_adder_pkg.sv
// Shared types and elaboration helpers for the chunked serial adder.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
//
// Contents:
//   state_t        - control FSM states (IDLE, CALC, DONE)
//   chunk_cfg_ok() - true when WIDTH is a non-zero multiple of CHUNK and CHUNK <= WIDTH
package chunked_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic bit chunk_cfg_ok(input int width, input int chunk);
      return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
   endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational W-bit adder slice: {cout_o, sum_o} = a_i + b_i + cin_i.
// Latency: 0 cycles (purely combinational).
// Backpressure: n/a.
//
// Ports:
//   a_i, b_i  - W-bit operand slices
//   cin_i     - carry into the slice
//   sum_o     - W-bit slice sum
//   cout_o    - carry out of the slice MSB
module chunk_adder #(
   parameter int W = 8
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic         cin_i,
   output logic [W-1:0] sum_o,
   output logic         cout_o
);

   assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, cin_i};

endmodule

// File: rtl/chunked_serial_adder.sv
// Multi-cycle WIDTH-bit adder, CHUNK bits per clock with a registered carry between chunks.
// Latency: handshake in cycle T -> out_valid in cycle T+NCHUNK+1; one op per NCHUNK+2 cycles.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE (no same-cycle re-accept).
//
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   in_valid / in_ready   - operand handshake (a, b, cin sampled on accept)
//   out_valid / out_ready - result handshake (sum, cout stable while out_valid)
//   busy                  - high while in CALC or DONE
// Build option CHUNKED_SERIAL_ADDER_ADDSUB_EN adds op (1 = subtract a - b) and ovf (signed overflow).
module chunked_serial_adder
   import chunked_adder_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef CHUNKED_SERIAL_ADDER_ADDSUB_EN
   input  logic             op,
   output logic             ovf,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
);

   localparam int NCHUNK = WIDTH / CHUNK;
   // Keep the index at least one bit wide so CHUNK == WIDTH still elaborates.
   localparam int IDXW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

   if (!chunk_cfg_ok(WIDTH, CHUNK)) begin : g_bad_cfg
      $error("chunked_serial_adder: WIDTH must be a multiple of CHUNK with 1 <= CHUNK <= WIDTH");
   end

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  a_q, a_d;
   logic [WIDTH-1:0]  b_q, b_d;      // effective operand (already inverted for subtract)
   logic [WIDTH-1:0]  sum_q, sum_d;
   logic              carry_q, carry_d;
   logic              cout_q, cout_d;
   logic [IDXW-1:0]   idx_q, idx_d;
`ifdef CHUNKED_SERIAL_ADDER_ADDSUB_EN
   logic              ovf_q, ovf_d;
`endif

   logic [CHUNK-1:0]  a_chunk, b_chunk, ch_sum;
   logic              ch_cout;

   // Select the active operand slices; constant-bound loop keeps every select static.
   always_comb begin
      a_chunk = '0;
      b_chunk = '0;
      for (int k = 0; k < NCHUNK; k++) begin
         if (idx_q == IDXW'(k)) begin
            a_chunk = a_q[k*CHUNK +: CHUNK];
            b_chunk = b_q[k*CHUNK +: CHUNK];
         end
      end
   end

   chunk_adder #(.W(CHUNK)) u_chunk_adder (
      .a_i    (a_chunk),
      .b_i    (b_chunk),
      .cin_i  (carry_q),
      .sum_o  (ch_sum),
      .cout_o (ch_cout)
   );

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      sum_d     = sum_q;
      carry_d   = carry_q;
      cout_d    = cout_q;
      idx_d     = idx_q;
`ifdef CHUNKED_SERIAL_ADDER_ADDSUB_EN
      ovf_d     = ovf_q;
`endif
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;

      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) begin
               a_d   = a;
`ifdef CHUNKED_SERIAL_ADDER_ADDSUB_EN
               // Subtract is a + ~b + 1: invert b once here and seed the carry with 1.
               b_d     = op ? ~b : b;
               carry_d = op ? 1'b1 : cin;
`else
               b_d     = b;
               carry_d = cin;
`endif
               idx_d   = '0;
               state_d = CALC;
            end
         end

         CALC: begin
            for (int k = 0; k < NCHUNK; k++) begin
               if (idx_q == IDXW'(k)) begin
                  sum_d[k*CHUNK +: CHUNK] = ch_sum;
               end
            end
            carry_d = ch_cout;
            idx_d   = idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
               cout_d  = ch_cout;
`ifdef CHUNKED_SERIAL_ADDER_ADDSUB_EN
               // The top chunk's sum MSB is the result MSB; b_q MSB is the effective operand MSB.
               ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (ch_sum[CHUNK-1] != a_q[WIDTH-1]);
`endif
               state_d = DONE;
            end
         end

         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         idx_q   <= '0;
`ifdef CHUNKED_SERIAL_ADDER_ADDSUB_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         idx_q   <= idx_d;
`ifdef CHUNKED_SERIAL_ADDER_ADDSUB_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign sum  = sum_q;
   assign cout = cout_q;
`ifdef CHUNKED_SERIAL_ADDER_ADDSUB_EN
   assign ovf  = ovf_q;
`endif

endmodule
